argmax_classifier: RTL

Final classification stage of the neural network datapath. It consumes the output-layer neuron activations of one sample as a stream, one per cycle, and tracks the running maximum. When the last activation arrives it emits the winning class index on `result` with a one-cycle `batch_done` pulse. After a programmed number of samples it raises `done`, which gives the top level and the accuracy-checking bench their per-sample and end-of-run events.

---
 rtl/argmax_classifier_if.sv | 24 ++
 rtl/argmax_classifier.sv | 126 ++++++++++++
 2 files changed

// File: rtl/argmax_classifier_if.sv
// Stream and status bundle for argmax_classifier: activation input handshake,
// run control and classification results.
`timescale 1ns/1ps
interface argmax_classifier_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [7:0]        result;
  logic              batch_done;
  logic              done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, result, batch_done, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, result, batch_done, done
  );
endinterface

// File: rtl/argmax_classifier.sv
// Streaming argmax over NUM_CLASSES signed activations per sample, NUM_SAMPLES per run.
// Optional macro ARGMAX_TIE_LAST_EN: ties go to the highest index instead of the lowest.
`timescale 1ns/1ps
module argmax_classifier #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10,
  parameter int NUM_SAMPLES = 750
) (
  input  logic clk,
  input  logic rst,
  argmax_classifier_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                   state_r;
  logic signed [DATA_W-1:0] max_r;
  logic [7:0]               argmax_r;
  logic [7:0]               class_cnt_r;
  logic [7:0]               result_r;
  logic [9:0]               sample_cnt_r;
  logic                     in_ready_r;
  logic                     batch_done_r;
  logic                     done_r;

  logic signed [DATA_W-1:0] data_s;
  logic                     accept_s;
  logic                     replace_s;
  logic                     last_class_s;
  logic                     last_sample_s;
  logic [7:0]               final_idx_s;

  // Accept/compare decode for the current activation.
  always_comb begin
    data_s        = $signed(bus.in_data);
    accept_s      = (state_r == SCAN) && bus.in_valid;
    last_class_s  = (class_cnt_r == 8'(NUM_CLASSES - 1));
    last_sample_s = ((sample_cnt_r + 10'd1) == 10'(NUM_SAMPLES));
    if (class_cnt_r == 8'd0) begin
      replace_s = 1'b1;
    end else begin
`ifdef ARGMAX_TIE_LAST_EN
      replace_s = (data_s >= max_r);
`else
      replace_s = (data_s > max_r);
`endif
    end
    if (replace_s) begin
      final_idx_s = class_cnt_r;
    end else begin
      final_idx_s = argmax_r;
    end
  end

  // Control FSM with registered outputs; done is raised one cycle early so it
  // lines up with the final batch_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      max_r        <= '0;
      argmax_r     <= 8'd0;
      class_cnt_r  <= 8'd0;
      result_r     <= 8'd0;
      sample_cnt_r <= 10'd0;
      in_ready_r   <= 1'b0;
      batch_done_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r      <= SCAN;
            in_ready_r   <= 1'b1;
            sample_cnt_r <= 10'd0;
            class_cnt_r  <= 8'd0;
            done_r       <= 1'b0;
          end
        end
        SCAN: begin
          if (accept_s) begin
            class_cnt_r <= class_cnt_r + 8'd1;
            if (replace_s) begin
              max_r    <= data_s;
              argmax_r <= class_cnt_r;
            end
            if (last_class_s) begin
              state_r      <= EMIT;
              in_ready_r   <= 1'b0;
              batch_done_r <= 1'b1;
              result_r     <= final_idx_s;
              if (last_sample_s) begin
                done_r <= 1'b1;
              end
            end
          end
        end
        EMIT: begin
          batch_done_r <= 1'b0;
          sample_cnt_r <= sample_cnt_r + 10'd1;
          class_cnt_r  <= 8'd0;
          if (last_sample_s) begin
            state_r <= IDLE;
          end else begin
            state_r    <= SCAN;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          in_ready_r   <= 1'b0;
          batch_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.result     = result_r;
  assign bus.batch_done = batch_done_r;
  assign bus.done       = done_r;

endmodule
